// File: rtl/seven_seg_pkg.sv
// Segment encodings shared by the display driver and the scan-capture monitor.
// Patterns are active-low, written g..a (bit6 = g, bit0 = a).
package seven_seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] BCD_ERR   = 4'hF;

endpackage

// File: rtl/seven_segment_pattern_decoder.sv
// Combinational segment-pattern to BCD decoder; blank reads as 0 with the blank flag,
// anything unrecognised reads as BCD_ERR with the error flag.
module seven_segment_pattern_decoder
   import seven_seg_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] bcd_o,
   output logic       blank_o,
   output logic       err_o
);

   always_comb begin
      bcd_o   = '0;
      blank_o = 1'b0;
      err_o   = 1'b0;
      case (seg_i)
         SEG_0:     bcd_o = 4'd0;
         SEG_1:     bcd_o = 4'd1;
         SEG_2:     bcd_o = 4'd2;
         SEG_3:     bcd_o = 4'd3;
         SEG_4:     bcd_o = 4'd4;
         SEG_5:     bcd_o = 4'd5;
         SEG_6:     bcd_o = 4'd6;
         SEG_7:     bcd_o = 4'd7;
         SEG_8:     bcd_o = 4'd8;
         SEG_9:     bcd_o = 4'd9;
         SEG_BLANK: blank_o = 1'b1;
         default: begin
            bcd_o = BCD_ERR;
            err_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/seven_segment_scan_capture.sv
// Loopback monitor for a multiplexed 7-segment bus: debounces each digit dwell,
// assembles a full scan frame and publishes it with a one-cycle valid pulse.
module seven_segment_scan_capture
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65536
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [6:0]                segments,
   input  logic [NUM_DIGITS-1:0]     anodes,
   output logic [4*NUM_DIGITS-1:0]   digits_bcd,
   output logic [NUM_DIGITS-1:0]     blank_mask,
   output logic                      frame_valid,
   output logic                      frame_changed,
   output logic                      decode_error,
   output logic                      timeout
);

   localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [SW-1:0] STB = SW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

   typedef logic [NUM_DIGITS-1:0][3:0] bcd_vec_t;

   logic [6:0]            seg_s1_q, seg_s2_q;
   logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;

   logic [KW-1:0]         prev_k_q, prev_k_d;
   logic [6:0]            prev_seg_q, prev_seg_d;
   logic [SW-1:0]         stab_q, stab_d;
   logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

   bcd_vec_t              stage_bcd_q, stage_bcd_d;
   logic [NUM_DIGITS-1:0] stage_blank_q, stage_blank_d;
   logic [NUM_DIGITS-1:0] seen_q, seen_d;
   logic                  err_q, err_d;

   bcd_vec_t              digits_q, digits_d;
   logic [NUM_DIGITS-1:0] blank_q, blank_d;
   logic                  fv_q, fv_d;
   logic                  chg_q, chg_d;
   logic                  decerr_q, decerr_d;
   logic                  tmo_q, tmo_d;

   logic [NUM_DIGITS-1:0] an_act;
   logic                  sample_vld;
   logic [KW-1:0]         k;
   logic                  same, commit;
   logic [3:0]            dec_bcd;
   logic                  dec_blank, dec_err;

   seven_segment_pattern_decoder u_dec (
      .seg_i   (seg_s2_q),
      .bcd_o   (dec_bcd),
      .blank_o (dec_blank),
      .err_o   (dec_err)
   );

   always_comb begin
      an_act     = ~an_s2_q;
      sample_vld = $onehot(an_act);
      k          = '0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (an_act[i]) k = i[KW-1:0];
      end
   end

   // Stability counter saturates at STB so a long dwell commits exactly once.
   always_comb begin
      same       = (stab_q != '0) && (k == prev_k_q) && (seg_s2_q == prev_seg_q);
      prev_k_d   = sample_vld ? k : prev_k_q;
      prev_seg_d = sample_vld ? seg_s2_q : prev_seg_q;
      if (!sample_vld)      stab_d = '0;
      else if (!same)       stab_d = SW'(1);
      else if (stab_q == STB) stab_d = stab_q;
      else                  stab_d = stab_q + SW'(1);
      commit = sample_vld && (stab_d == STB) && (stab_q != STB);
   end

   always_comb begin
      stage_bcd_d   = stage_bcd_q;
      stage_blank_d = stage_blank_q;
      seen_d        = seen_q;
      err_d         = err_q;
      digits_d      = digits_q;
      blank_d       = blank_q;
      fv_d          = 1'b0;
      chg_d         = chg_q;
      decerr_d      = decerr_q;
      tmo_cnt_d     = tmo_cnt_q;
      tmo_d         = tmo_q;

      if (&seen_q) begin
         digits_d = stage_bcd_q;
         blank_d  = stage_blank_q;
         fv_d     = 1'b1;
         chg_d    = (stage_bcd_q != digits_q) || (stage_blank_q != blank_q);
         decerr_d = err_q;
         seen_d   = '0;
         err_d    = 1'b0;
      end

      if (commit) begin
         stage_bcd_d[k]   = dec_bcd;
         stage_blank_d[k] = dec_blank;
         err_d            = err_d | dec_err;
         seen_d[k]        = 1'b1;
         tmo_cnt_d        = '0;
         tmo_d            = 1'b0;
      end else if (tmo_cnt_q != TMO) begin
         tmo_cnt_d = tmo_cnt_q + TW'(1);
         // Expiry discards the partial frame; a fresh full scan is needed afterwards.
         if (tmo_cnt_d == TMO) begin
            tmo_d  = 1'b1;
            seen_d = '0;
            err_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_s1_q      <= '1;
         seg_s2_q      <= '1;
         an_s1_q       <= '1;
         an_s2_q       <= '1;
         prev_k_q      <= '0;
         prev_seg_q    <= '1;
         stab_q        <= '0;
         tmo_cnt_q     <= '0;
         stage_bcd_q   <= '0;
         stage_blank_q <= '0;
         seen_q        <= '0;
         err_q         <= 1'b0;
         digits_q      <= '0;
         blank_q       <= '1;
         fv_q          <= 1'b0;
         chg_q         <= 1'b0;
         decerr_q      <= 1'b0;
         tmo_q         <= 1'b0;
      end else begin
         seg_s1_q      <= segments;
         seg_s2_q      <= seg_s1_q;
         an_s1_q       <= anodes;
         an_s2_q       <= an_s1_q;
         prev_k_q      <= prev_k_d;
         prev_seg_q    <= prev_seg_d;
         stab_q        <= stab_d;
         tmo_cnt_q     <= tmo_cnt_d;
         stage_bcd_q   <= stage_bcd_d;
         stage_blank_q <= stage_blank_d;
         seen_q        <= seen_d;
         err_q         <= err_d;
         digits_q      <= digits_d;
         blank_q       <= blank_d;
         fv_q          <= fv_d;
         chg_q         <= chg_d;
         decerr_q      <= decerr_d;
         tmo_q         <= tmo_d;
      end
   end

   assign digits_bcd    = digits_q;
   assign blank_mask    = blank_q;
   assign frame_valid   = fv_q;
   assign frame_changed = chg_q;
   assign decode_error  = decerr_q;
   assign timeout       = tmo_q;

endmodule

// File: tb/tb_seven_segment_scan_capture.sv
// Directed bench for seven_segment_scan_capture: scans known digit patterns and
// compares published frames against hand-computed values.
module tb_seven_segment_scan_capture;
   import seven_seg_pkg::*;

   localparam int unsigned ND  = 4;
   localparam int unsigned TMO = 300;

   logic          clk = 1'b0;
   logic          rst;
   logic [6:0]    segments;
   logic [ND-1:0] anodes;
   logic [15:0]   digits_bcd;
   logic [ND-1:0] blank_mask;
   logic          frame_valid, frame_changed, decode_error, timeout;

   int unsigned n_run  = 0;
   int unsigned n_fail = 0;
   int unsigned fv_count = 0;
   int unsigned fv_base;
   logic [15:0] cap_digits = '0;
   logic [3:0]  cap_blank  = '0;
   logic        cap_chg    = 1'b0;
   logic        cap_err    = 1'b0;

   seven_segment_scan_capture #(
      .NUM_DIGITS     (ND),
      .STABLE_CYCLES  (4),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .segments      (segments),
      .anodes        (anodes),
      .digits_bcd    (digits_bcd),
      .blank_mask    (blank_mask),
      .frame_valid   (frame_valid),
      .frame_changed (frame_changed),
      .decode_error  (decode_error),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_valid) begin
         fv_count   = fv_count + 1;
         cap_digits = digits_bcd;
         cap_blank  = blank_mask;
         cap_chg    = frame_changed;
         cap_err    = decode_error;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_digit(input int unsigned k, input logic [6:0] pat, input int unsigned n);
      anodes   = ~(4'b0001 << k);
      segments = pat;
      cycles(n);
   endtask

   task automatic idle(input int unsigned n);
      anodes   = '1;
      segments = SEG_BLANK;
      cycles(n);
   endtask

   task automatic scan(input logic [6:0] p3, input logic [6:0] p2,
                       input logic [6:0] p1, input logic [6:0] p0,
                       input logic [6:0] ghost, input bit use_ghost);
      logic [6:0] pats [4];
      pats[0] = p0; pats[1] = p1; pats[2] = p2; pats[3] = p3;
      for (int d = 3; d >= 0; d--) begin
         if (use_ghost) drive_digit(d, ghost, 2);
         drive_digit(d, pats[d], 16);
      end
   endtask

   task automatic wait_negedge();
      @(negedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      anodes   = '1;
      segments = SEG_BLANK;
      cycles(2);
      rst = 1'b0;
      wait_negedge();
      chk("rst_digits",  digits_bcd,   16'h0000);
      chk("rst_blank",   blank_mask,   4'hF);
      chk("rst_fv",      frame_valid,  1'b0);
      chk("rst_chg",     frame_changed, 1'b0);
      chk("rst_err",     decode_error, 1'b0);
      chk("rst_tmo",     timeout,      1'b0);
      cycles(1);

      fv_base = fv_count;
      scan(SEG_1, SEG_2, SEG_3, SEG_4, SEG_BLANK, 1'b0);
      chk("f1_count",  fv_count - fv_base, 1);
      chk("f1_digits", cap_digits, 16'h1234);
      chk("f1_blank",  cap_blank,  4'h0);
      chk("f1_chg",    cap_chg,    1'b1);
      chk("f1_err",    cap_err,    1'b0);

      fv_base = fv_count;
      scan(SEG_1, SEG_2, SEG_3, SEG_4, SEG_BLANK, 1'b0);
      chk("f2_count",  fv_count - fv_base, 1);
      chk("f2_digits", cap_digits, 16'h1234);
      chk("f2_chg",    cap_chg,    1'b0);

      fv_base = fv_count;
      scan(SEG_4, SEG_3, SEG_2, SEG_1, SEG_8, 1'b1);
      chk("glitch_count",  fv_count - fv_base, 1);
      chk("glitch_digits", cap_digits, 16'h4321);
      chk("glitch_chg",    cap_chg,    1'b1);
      chk("glitch_err",    cap_err,    1'b0);

      fv_base = fv_count;
      scan(SEG_5, 7'b0111111, SEG_7, SEG_9, SEG_BLANK, 1'b0);
      chk("bad_count",  fv_count - fv_base, 1);
      chk("bad_digits", cap_digits, 16'h5F79);
      chk("bad_err",    cap_err,    1'b1);

      fv_base = fv_count;
      scan(SEG_9, SEG_8, SEG_7, SEG_6, SEG_BLANK, 1'b0);
      chk("clr_count",  fv_count - fv_base, 1);
      chk("clr_digits", cap_digits, 16'h9876);
      chk("clr_err",    cap_err,    1'b0);

      fv_base = fv_count;
      scan(SEG_BLANK, SEG_0, SEG_0, SEG_0, SEG_BLANK, 1'b0);
      chk("blank_count",  fv_count - fv_base, 1);
      chk("blank_mask",   cap_blank,  4'b1000);
      chk("blank_digits", cap_digits, 16'h0000);
      chk("blank_chg",    cap_chg,    1'b1);

      fv_base = fv_count;
      drive_digit(3, SEG_1, 16);
      drive_digit(2, SEG_2, 16);
      idle(TMO - 20);
      chk("tmo_before", timeout, 1'b0);
      idle(30);
      chk("tmo_after",  timeout, 1'b1);
      chk("tmo_nofv",   fv_count - fv_base, 0);
      drive_digit(1, SEG_5, 16);
      chk("tmo_clear",  timeout, 1'b0);
      drive_digit(0, SEG_6, 16);
      chk("tmo_discard", fv_count - fv_base, 0);
      drive_digit(3, SEG_7, 16);
      drive_digit(2, SEG_8, 16);
      chk("tmo_fresh_count",  fv_count - fv_base, 1);
      chk("tmo_fresh_digits", cap_digits, 16'h7856);
      chk("tmo_fresh_blank",  cap_blank,  4'h0);
      chk("tmo_fresh_tmo",    timeout,    1'b0);

      idle(4);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
